// File: rtl/seq_generator.sv
// Button-sequence generator: fills 15 two-bit symbols from an 8-bit LFSR, entry 15 is a fixed terminator.
// Optional build macro SEQ_GEN_LATCH_SEED_EN: remember the last nonzero seed and reuse it when seed is 0.
module seq_generator (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  seed,
    input  logic [3:0]  rd_idx,
    output logic [1:0]  rd_data,
    output logic [31:0] seq_flat,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam logic [3:0] LAST_IDX     = 4'd14;

    state_t            state_q, state_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [3:0]        wr_idx_q, wr_idx_d;
    logic [14:0][1:0]  mem_q, mem_d;
    logic [15:0][1:0]  entries;
    logic [1:0]        cand;
    logic              fb;

`ifdef SEQ_GEN_LATCH_SEED_EN
    logic [7:0]        last_seed_q, last_seed_d;
`endif

    assign entries  = {2'b11, mem_q};
    assign seq_flat = entries;
    assign rd_data  = entries[rd_idx];
    assign busy     = (state_q == FILL);
    assign done     = (state_q == DONE);

    assign cand = lfsr_q[1:0];
    assign fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        wr_idx_d = wr_idx_q;
        mem_d    = mem_q;
`ifdef SEQ_GEN_LATCH_SEED_EN
        last_seed_d = last_seed_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wr_idx_d = '0;
                    state_d  = FILL;
`ifdef SEQ_GEN_LATCH_SEED_EN
                    if (seed != 8'h00) begin
                        lfsr_d      = seed;
                        last_seed_d = seed;
                    end else begin
                        lfsr_d = last_seed_q;
                    end
`else
                    lfsr_d = (seed != 8'h00) ? seed : DEFAULT_SEED;
`endif
                end
            end
            FILL: begin
                // LFSR steps every cycle; a rejected 11 candidate just costs one cycle
                lfsr_d = {lfsr_q[6:0], fb};
                if (cand != 2'b11) begin
                    mem_d[wr_idx_q] = cand;
                    wr_idx_d        = wr_idx_q + 4'd1;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= DEFAULT_SEED;
            wr_idx_q <= '0;
            mem_q    <= '0;
`ifdef SEQ_GEN_LATCH_SEED_EN
            last_seed_q <= DEFAULT_SEED;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            wr_idx_q <= wr_idx_d;
            mem_q    <= mem_d;
`ifdef SEQ_GEN_LATCH_SEED_EN
            last_seed_q <= last_seed_d;
`endif
        end
    end

endmodule

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 Port `start`, input, 1 bit: request to generate a new sequence, sampled each rising edge.
REQ-005 Port `seed`, input, 8 bits: LFSR seed, sampled on an accepted `start`.
REQ-006 Port `rd_idx`, input, 4 bits: index for the read port.
REQ-007 Port `rd_data`, output, 2 bits: sequence entry at `rd_idx`.
REQ-008 Port `seq_flat`, output, 32 bits: all 16 entries; entry i SHALL be on bits [2i+1:2i].
REQ-009 Port `busy`, output, 1 bit: high while in FILL.
REQ-010 Port `done`, output, 1 bit: one-cycle pulse when generation completes.

Function
REQ-011 Storage SHALL be 16 entries of 2 bits. Entries 0..14 SHALL hold button symbols 00/01/10. Entry 15 SHALL be the constant terminator 11 and SHALL never be written.
REQ-012 `rd_data` SHALL be a combinational read of entry[`rd_idx`] and SHALL reflect any write in the cycle after that write's edge; `rd_idx`=15 SHALL return 11.
REQ-013 The FSM SHALL have three states: IDLE, FILL and DONE.
REQ-014 IDLE, `start`=1: on that edge, lfsr <= `seed` (or 8'hA5 if `seed`=0), wr_idx <= 0, state <= FILL.
REQ-015 LFSR: 8-bit Fibonacci; next = {lfsr[6:0], fb}, where fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
REQ-016 FILL, every edge: candidate = lfsr[1:0].
- If candidate != 11, write entry[wr_idx] <= candidate and increment wr_idx.
- If candidate = 11, reject it: no write, wr_idx unchanged.
- The LFSR SHALL advance on every FILL edge, regardless of rejection.
REQ-017 FILL: the edge that writes entry 14 SHALL move the state to DONE.
REQ-018 DONE: `done`=1 and `busy`=0 for exactly one cycle, then unconditionally IDLE.
REQ-019 `start` SHALL be ignored in FILL and DONE; `start` held high in IDLE after DONE SHALL begin a new generation.
REQ-020 Minimum latency: `done` SHALL be high in the cycle after edge N+15, where N is the accepted-start edge. Each rejection SHALL add one cycle.
REQ-021 Entries not yet rewritten during FILL SHALL retain their prior values.

Reset
REQ-022 `rst`=1 SHALL override all other inputs, including mid-FILL, and on that edge set:
- state IDLE
- entries 0..14 to 00, entry 15 to 11
- lfsr 8'hA5, wr_idx 0
- `busy`=0, `done`=0
REQ-023 After reset, `seq_flat` SHALL be 32'hC0000000 and `rd_data` SHALL be 00 for `rd_idx` 0..14.

Configuration
REQ-024 Macro SEQ_GEN_LATCH_SEED_EN SHALL control seed latching.
- Defined: every accepted `start` with `seed`!=0 SHALL store `seed` in an internal last_seed register (reset value 8'hA5). `seed`=0 SHALL reload last_seed, reproducing the previous sequence.
- Undefined: `seed`=0 SHALL always load 8'hA5 and no last_seed register SHALL exist.

Verification
REQ-025 Reset, then read all indices -> entries 0..14 = 00, entry 15 = 11, `busy`=0, `done`=0.
REQ-026 `start`=1 with `seed`=8'hA5 for one cycle -> entries 0..3 = 01,10,01,10. `done` pulses exactly once with no 11 stored in entries 0..14. `done` comes no earlier than the cycle after edge N+15, and the cycle count equals 15 plus the number of rejected candidates.
REQ-027 Run with `seed`=8'h00, compare against the 8'hA5 run -> identical `seq_flat` in both builds (macro undefined; macro defined with no prior nonzero seed).
REQ-028 Assert `rst` on the 5th FILL cycle -> next cycle state IDLE, `busy`=0, `seq_flat`=32'hC0000000, and no `done` pulse.
REQ-029 Pulse `start` repeatedly during FILL -> no restart, a single `done`, contents match the undisturbed run.
REQ-030 Macro defined: start with 8'h3C, then start with 8'h00 -> both runs produce identical `seq_flat`. Macro undefined, same stimulus -> the second run matches the 8'hA5 result.
